// File: rtl/x2c_ctrl_wr_arb.sv
// -----------------------------------------------------------------------------
// x2c_ctrl_wr_arb
//   Round-robin write arbiter and descriptor sequencer for the x2c control
//   FIFO. Grants one requester at a time, and only when the FIFO can hold the
//   whole descriptor, so descriptors never interleave or split across a full
//   condition.
//
//   Optional feature macro: X2C_ARB_TIMEOUT_EN
//     When defined, an owner that stalls for TIMEOUT cycles is aborted and the
//     rest of its descriptor is written as PAD_WORD before done/err pulse.
//
// Ports
//   clk         in   single clock
//   reset_      in   asynchronous active-low reset
//   req         in   per-requester request level, held until done
//   req_len     in   descriptor length of requester i at [i*LW +: LW]
//   wr_vld      in   per-requester word valid
//   wr_data     in   word of requester i at [i*WIDTH +: WIDTH]
//   gnt         out  one-hot owner grant, high through the transfer
//   done        out  one-cycle pulse at end of descriptor / reject / abort
//   err         out  one-cycle pulse with done on reject or abort
//   fifo_wrreq  out  registered FIFO write strobe
//   fifo_data   out  registered FIFO write data
//   fifo_full   in   FIFO full flag
//   fifo_usedw  in   FIFO occupancy
// -----------------------------------------------------------------------------
module x2c_ctrl_wr_arb #(
  parameter int               NREQ     = 4,
  parameter int               WIDTH    = 32,
  parameter int               PTR      = 10,
  parameter int               LW       = 5,
  parameter int               MAXLEN   = 16,
  parameter int               TIMEOUT  = 64,
  parameter logic [WIDTH-1:0] PAD_WORD = 32'hDEAD_0000
) (
  input  logic                    clk,
  input  logic                    reset_,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LW-1:0]      req_len,
  input  logic [NREQ-1:0]         wr_vld,
  input  logic [NREQ*WIDTH-1:0]   wr_data,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [NREQ-1:0]         err,
  output logic                    fifo_wrreq,
  output logic [WIDTH-1:0]        fifo_data,
  input  logic                    fifo_full,
  input  logic [PTR:0]            fifo_usedw
);

  localparam int          IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTR:0] DEPTH   = {1'b1, {PTR{1'b0}}};
  localparam logic [LW:0]  MAXLEN_W = (LW+1)'(MAXLEN);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_XFER, S_SETTLE} state_t;

  state_t            r_state;
  logic [IW-1:0]     r_rr_ptr;
  logic [IW-1:0]     r_win;
  logic [LW-1:0]     r_cnt;
  logic              r_lat;      // winner latched while waiting for space
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_done;
  logic [NREQ-1:0]   r_err;
  logic              r_wrreq;
  logic [WIDTH-1:0]  r_data;

`ifdef X2C_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0]     r_stall;
  logic              r_pad;      // abort in progress: filling with PAD_WORD
`endif

  logic              w_pick_vld;
  logic [IW-1:0]     w_pick_idx;
  logic [IW:0]       w_j;
  logic [LW-1:0]     w_req_len;
  logic [WIDTH-1:0]  w_wr_data;
  logic [IW-1:0]     w_sel_idx;
  logic [LW-1:0]     w_sel_len;
  logic [PTR:0]      w_free;
  logic              w_len_bad;
  logic              w_fits;
  logic              w_accept;

  // First set request at or after r_rr_ptr; scanning from the far end lets
  // the nearest one overwrite the others.
  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_j        = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (w_j >= (IW+1)'(NREQ)) w_j = w_j - (IW+1)'(NREQ);
      if (req[w_j[IW-1:0]]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_j[IW-1:0];
      end
    end
  end

  always_comb begin
    w_req_len = '0;
    w_wr_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick_idx == IW'(i)) w_req_len = req_len[i*LW +: LW];
      if (r_win == IW'(i))      w_wr_data = wr_data[i*WIDTH +: WIDTH];
    end
  end

  // Once a winner is latched it keeps the slot until space appears, even if
  // a requester nearer r_rr_ptr shows up in the meantime.
  assign w_sel_idx = r_lat ? r_win : w_pick_idx;
  assign w_sel_len = r_lat ? r_cnt : w_req_len;
  assign w_free    = DEPTH - fifo_usedw;
  assign w_len_bad = (w_sel_len == '0) || ({1'b0, w_sel_len} > MAXLEN_W);
  assign w_fits    = ((PTR+1)'(w_sel_len) <= w_free) && !fifo_full;
  assign w_accept  = r_gnt[r_win] & wr_vld[r_win];

  function automatic logic [IW-1:0] f_next(input logic [IW-1:0] idx);
    return (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_win    <= '0;
      r_cnt    <= '0;
      r_lat    <= 1'b0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_err    <= '0;
      r_wrreq  <= 1'b0;
      r_data   <= '0;
`ifdef X2C_ARB_TIMEOUT_EN
      r_stall  <= '0;
      r_pad    <= 1'b0;
`endif
    end else begin
      r_done  <= '0;
      r_err   <= '0;
      r_wrreq <= 1'b0;
      unique case (r_state)
        S_IDLE: if (|req) r_state <= S_ARB;

        S_ARB: begin
          if (r_lat ? !req[r_win] : !w_pick_vld) begin
            r_lat   <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_len_bad) begin
            r_done[w_sel_idx] <= 1'b1;
            r_err[w_sel_idx]  <= 1'b1;
            r_rr_ptr          <= f_next(w_sel_idx);
            r_lat             <= 1'b0;
            r_state           <= S_SETTLE;
          end else if (w_fits) begin
            r_gnt[w_sel_idx] <= 1'b1;
            r_win            <= w_sel_idx;
            r_cnt            <= w_sel_len;
            r_lat            <= 1'b0;
            r_state          <= S_XFER;
          end else begin
            r_lat <= 1'b1;
            r_win <= w_sel_idx;
            r_cnt <= w_sel_len;
          end
        end

        S_XFER: begin
          if (w_accept) begin
            r_wrreq <= 1'b1;
            r_data  <= w_wr_data;
            r_cnt   <= r_cnt - 1'b1;
`ifdef X2C_ARB_TIMEOUT_EN
            r_stall <= '0;
`endif
            if (r_cnt == LW'(1)) begin
              r_gnt         <= '0;
              r_done[r_win] <= 1'b1;
              r_rr_ptr      <= f_next(r_win);
              r_state       <= S_SETTLE;
            end
          end
`ifdef X2C_ARB_TIMEOUT_EN
          else if (r_pad) begin
            r_wrreq <= 1'b1;
            r_data  <= PAD_WORD;
            r_cnt   <= r_cnt - 1'b1;
            if (r_cnt == LW'(1)) begin
              r_pad         <= 1'b0;
              r_done[r_win] <= 1'b1;
              r_err[r_win]  <= 1'b1;
              r_rr_ptr      <= f_next(r_win);
              r_state       <= S_SETTLE;
            end
          end else if (r_stall == SW'(TIMEOUT - 1)) begin
            // Owner has stalled TIMEOUT cycles: take the grant away and pad.
            r_gnt   <= '0;
            r_pad   <= 1'b1;
            r_stall <= '0;
          end else begin
            r_stall <= r_stall + 1'b1;
          end
`endif
        end

        // One cycle for fifo_usedw to catch up with the last write.
        S_SETTLE: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign done       = r_done;
  assign err        = r_err;
  assign fifo_wrreq = r_wrreq;
  assign fifo_data  = r_data;

  // The space check must make a write into a full FIFO impossible.
  a_no_wr_full: assert property (@(posedge clk) disable iff (!reset_)
    !(fifo_wrreq && fifo_full));

  // Lengths up to MAXLEN must be encodable, and the abort settings must be
  // usable whether or not the abort path is built in.
  a_cfg: assert property (@(posedge clk)
    (NREQ >= 2) && (NREQ <= 8) && (MAXLEN < (1 << LW)) && (TIMEOUT > 0) &&
    !$isunknown(PAD_WORD));

endmodule
